// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/REGREAD/ALU/MEM/WB/PCUPD with registered stage enables.
// Latency 6 cycles ALU ops, 5 jumps/illegal, 6+wait memory (+1 WB for reads); stalls only in FETCH (i_run) and MEM (i_mem_ready).
module control_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_run,
  input  logic [15:0] i_instr,
  input  logic        i_mem_ready,
  input  logic        i_shld_branch,
  input  logic [15:0] i_alu_result,
  output logic [15:0] o_pc,
  output logic        o_fetch_req,
  output logic        o_en_decode,
  output logic        o_en_regread,
  output logic        o_en_alu,
  output logic        o_en_regwrite,
  output logic        o_en_mem,
  output logic        o_mem_we,
  output logic [4:0]  o_aluop,
  output logic [7:0]  o_imm,
  output logic        o_illegal,
  output logic [15:0] o_retired,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_REGREAD = 3'd2,
    S_ALU     = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_PCUPD   = 3'd6
  } state_t;

  state_t      state_q;
  state_t      state_nxt;
  logic [15:0] ir_q;
  logic [15:0] pc_q;
  logic [15:0] retired_q;
  logic        en_decode_q;
  logic        en_regread_q;
  logic        en_alu_q;
  logic        en_regwrite_q;
  logic        en_mem_q;
  logic        mem_we_q;
  logic        illegal_q;

  logic [3:0]  opcode;
  logic        is_rdmem;
  logic        is_wrmem;
  logic        is_jump;
  logic        is_illegal;
  logic        fetch_accept;
  logic        ir_unused;

  assign opcode       = ir_q[15:12];
  assign is_rdmem     = (opcode == 4'd6);
  assign is_wrmem     = (opcode == 4'd7);
  assign is_jump      = (opcode == 4'd12) || (opcode == 4'd13);
  assign is_illegal   = (opcode == 4'd14) || (opcode == 4'd15);
  assign fetch_accept = (state_q == S_FETCH) && i_run && i_mem_ready;
  // Register-field bits are decoded downstream, not by the sequencer.
  assign ir_unused    = ^ir_q[10:8];

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_FETCH:   if (i_run && i_mem_ready) state_nxt = S_DECODE;
      S_DECODE:  state_nxt = S_REGREAD;
      S_REGREAD: state_nxt = S_ALU;
      S_ALU: begin
        if (is_rdmem || is_wrmem)       state_nxt = S_MEM;
        else if (is_jump || is_illegal) state_nxt = S_PCUPD;
        else                            state_nxt = S_WB;
      end
      S_MEM:     if (i_mem_ready) state_nxt = is_wrmem ? S_PCUPD : S_WB;
      S_WB:      state_nxt = S_PCUPD;
      S_PCUPD:   state_nxt = S_FETCH;
      default:   state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_FETCH;
      ir_q      <= 16'h0000;
      pc_q      <= RESET_PC;
      retired_q <= 16'h0000;
    end else begin
      state_q <= state_nxt;
      if (fetch_accept) ir_q <= i_instr;
      if (state_q == S_PCUPD) begin
        pc_q      <= (is_jump && i_shld_branch) ? i_alu_result : pc_q + 16'd1;
        retired_q <= retired_q + 16'd1;
      end
    end
  end

  // Enables are decoded from the next state so each one is a flop aligned with its own state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_decode_q   <= 1'b0;
      en_regread_q  <= 1'b0;
      en_alu_q      <= 1'b0;
      en_regwrite_q <= 1'b0;
      en_mem_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      en_decode_q   <= (state_nxt == S_DECODE);
      en_regread_q  <= (state_nxt == S_REGREAD);
      en_alu_q      <= (state_nxt == S_ALU);
      en_regwrite_q <= (state_nxt == S_WB);
      en_mem_q      <= (state_nxt == S_MEM);
      mem_we_q      <= (state_nxt == S_MEM) && is_wrmem;
      illegal_q     <= (state_nxt == S_ALU) && is_illegal;
    end
  end

  assign o_pc          = pc_q;
  assign o_fetch_req   = (state_q == S_FETCH) && i_run;
  assign o_en_decode   = en_decode_q;
  assign o_en_regread  = en_regread_q;
  assign o_en_alu      = en_alu_q;
  assign o_en_regwrite = en_regwrite_q;
  assign o_en_mem      = en_mem_q;
  assign o_mem_we      = mem_we_q;
  assign o_aluop       = ir_q[15:11];
  assign o_imm         = ir_q[7:0];
  assign o_illegal     = illegal_q;
  assign o_retired     = retired_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: driver pushes hand-computed expectations, monitor checks at each retirement.
module tb_control_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_run = 1'b0;
  logic [15:0] i_instr = 16'h0000;
  logic        i_mem_ready = 1'b0;
  logic        i_shld_branch = 1'b0;
  logic [15:0] i_alu_result = 16'h0000;
  logic [15:0] o_pc;
  logic        o_fetch_req;
  logic        o_en_decode;
  logic        o_en_regread;
  logic        o_en_alu;
  logic        o_en_regwrite;
  logic        o_en_mem;
  logic        o_mem_we;
  logic [4:0]  o_aluop;
  logic [7:0]  o_imm;
  logic        o_illegal;
  logic [15:0] o_retired;
  logic [2:0]  o_state;

  control_unit dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_run         (i_run),
    .i_instr       (i_instr),
    .i_mem_ready   (i_mem_ready),
    .i_shld_branch (i_shld_branch),
    .i_alu_result  (i_alu_result),
    .o_pc          (o_pc),
    .o_fetch_req   (o_fetch_req),
    .o_en_decode   (o_en_decode),
    .o_en_regread  (o_en_regread),
    .o_en_alu      (o_en_alu),
    .o_en_regwrite (o_en_regwrite),
    .o_en_mem      (o_en_mem),
    .o_mem_we      (o_mem_we),
    .o_aluop       (o_aluop),
    .o_imm         (o_imm),
    .o_illegal     (o_illegal),
    .o_retired     (o_retired),
    .o_state       (o_state)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ret;
    int          cyc;
    int          rw;
    int          mem;
    int          we;
    int          ill;
    logic [4:0]  aluop;
    logic [7:0]  imm;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic chk_reset(string tag);
    chk({tag, "_state"},    32'(o_state),       32'd0);
    chk({tag, "_pc"},       32'(o_pc),          32'h0000);
    chk({tag, "_retired"},  32'(o_retired),     32'd0);
    chk({tag, "_decode"},   32'(o_en_decode),   32'd0);
    chk({tag, "_regread"},  32'(o_en_regread),  32'd0);
    chk({tag, "_alu"},      32'(o_en_alu),      32'd0);
    chk({tag, "_regwrite"}, 32'(o_en_regwrite), 32'd0);
    chk({tag, "_en_mem"},   32'(o_en_mem),      32'd0);
    chk({tag, "_mem_we"},   32'(o_mem_we),      32'd0);
    chk({tag, "_illegal"},  32'(o_illegal),     32'd0);
    chk({tag, "_aluop"},    32'(o_aluop),       32'd0);
    chk({tag, "_imm"},      32'(o_imm),         32'd0);
  endtask

  // Monitor: accumulates per-instruction activity, compares at PCUPD and again after the PC update.
  initial begin
    int   cyc = 0, rw = 0, mem = 0, we = 0, ill = 0, ctl = 0, fr = 0;
    bit   pend = 0;
    logic [2:0] st;
    exp_t cur;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        cyc = 0; rw = 0; mem = 0; we = 0; ill = 0; ctl = 0; fr = 0; pend = 0;
      end else begin
        if (pend) begin
          chk("pc_after_retire", 32'(o_pc), 32'(cur.pc));
          chk("retired_count",   32'(o_retired), 32'(cur.ret));
          pend = 0;
        end
        st = o_state;
        if (st == 3'd0) begin
          if (o_fetch_req !== i_run) fr++;
          if (i_run && i_mem_ready) begin
            cyc = 1; rw = 0; mem = 0; we = 0; ill = 0; ctl = 0;
          end
        end else begin
          cyc++;
        end
        if (o_en_regwrite) rw++;
        if (o_en_mem) mem++;
        if (o_mem_we) we++;
        if (o_illegal) ill++;
        if (o_en_decode   !== (st == 3'd1)) ctl++;
        if (o_en_regread  !== (st == 3'd2)) ctl++;
        if (o_en_alu      !== (st == 3'd3)) ctl++;
        if (o_en_mem      !== (st == 3'd4)) ctl++;
        if (o_en_regwrite !== (st == 3'd5)) ctl++;
        if (o_mem_we && st != 3'd4) ctl++;
        if (o_illegal && st != 3'd3) ctl++;
        if (st >= 3'd1 && st <= 3'd6 && sb_q.size() > 0)
          if (o_aluop !== sb_q[0].aluop || o_imm !== sb_q[0].imm) ctl++;
        if (st == 3'd6) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_retire: got retirement at pc 0x%0h, expected none", o_pc);
          end else begin
            cur = sb_q.pop_front();
            chk("latency",         32'(cyc), 32'(cur.cyc));
            chk("regwrite_cycles", 32'(rw),  32'(cur.rw));
            chk("mem_cycles",      32'(mem), 32'(cur.mem));
            chk("mem_we_cycles",   32'(we),  32'(cur.we));
            chk("illegal_pulses",  32'(ill), 32'(cur.ill));
            chk("ctl_consistency", 32'(ctl), 32'd0);
            chk("fetch_req_rule",  32'(fr),  32'd0);
            fr   = 0;
            pend = 1;
          end
        end
      end
    end
  end

  // Driver: called at posedge+1 with the DUT in FETCH; returns at posedge+1 once it is back in FETCH.
  task automatic run_instr(input logic [15:0] instr, input logic br, input logic [15:0] res,
                           input int waits, input int stall, input bit drop_run,
                           input logic [15:0] e_pc, input logic [15:0] e_ret,
                           input int e_cyc, input int e_rw, input int e_mem, input int e_we, input int e_ill);
    exp_t e;
    int   left = waits;
    bit   seen = 0;
    bit   done = 0;
    int   guard = 0;
    e.pc = e_pc; e.ret = e_ret; e.cyc = e_cyc; e.rw = e_rw; e.mem = e_mem; e.we = e_we; e.ill = e_ill;
    e.aluop = instr[15:11];
    e.imm   = instr[7:0];
    sb_q.push_back(e);
    i_instr = instr; i_shld_branch = br; i_alu_result = res; i_mem_ready = 1'b1;
    if (stall > 0) begin
      i_run = 1'b0;
      repeat (stall) begin @(posedge i_clk); #1; end
    end
    i_run = 1'b1;
    while (!done && guard < 60) begin
      @(posedge i_clk); #1;
      guard++;
      if (drop_run && o_state == 3'd1) i_run = 1'b0;
      if (o_state == 3'd4 && left > 0) begin
        i_mem_ready = 1'b0;
        left--;
      end else begin
        i_mem_ready = 1'b1;
      end
      if (o_state == 3'd6) seen = 1;
      else if (seen && o_state == 3'd0) done = 1;
    end
    chk("instr_completes", 32'(done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit reached;
    int guard;
    repeat (3) @(posedge i_clk);
    #1;
    chk_reset("por");
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    //        instr    br  result   wt st dr  e_pc     e_ret cyc rw mem we ill
    run_instr(16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0001, 16'd1, 6, 1, 0, 0, 0); // ADD
    run_instr(16'h705A, 0, 16'h0000, 3, 0, 0, 16'h0002, 16'd2, 9, 0, 4, 4, 0); // Wrmem, 3 waits
    run_instr(16'h6011, 0, 16'h0000, 1, 0, 1, 16'h0003, 16'd3, 8, 1, 2, 0, 0); // Rdmem, run dropped in flight
    run_instr(16'hC077, 1, 16'h0040, 0, 2, 0, 16'h0040, 16'd4, 5, 0, 0, 0, 0); // JMPA taken, after stall
    run_instr(16'hF033, 0, 16'h0000, 0, 0, 0, 16'h0041, 16'd5, 5, 0, 0, 0, 1); // opcode 15
    run_instr(16'hE8FF, 1, 16'h0999, 0, 0, 0, 16'h0042, 16'd6, 5, 0, 0, 0, 1); // opcode 14, branch ignored
    run_instr(16'hC500, 1, 16'hFFFF, 0, 0, 0, 16'hFFFF, 16'd7, 5, 0, 0, 0, 0); // JMPA to FFFF
    run_instr(16'hD000, 0, 16'h1234, 0, 0, 0, 16'h0000, 16'd8, 5, 0, 0, 0, 0); // JMPR not taken, wrap
    run_instr(16'h1812, 1, 16'h5555, 0, 0, 0, 16'h0001, 16'd9, 6, 1, 0, 0, 0); // ALU op ignores branch
    run_instr(16'hD9AA, 1, 16'h0100, 0, 0, 0, 16'h0100, 16'd10, 5, 0, 0, 0, 0); // JMPR taken
    run_instr(16'h6400, 0, 16'h0000, 0, 0, 0, 16'h0101, 16'd11, 7, 1, 1, 0, 0); // Rdmem, no wait

    // Reset while a Wrmem is stuck waiting in MEM.
    i_instr = 16'h7123; i_mem_ready = 1'b1; i_run = 1'b1;
    reached = 0;
    guard = 0;
    while (!reached && guard < 20) begin
      @(posedge i_clk); #1;
      guard++;
      if (o_state == 3'd4) begin
        reached = 1;
        i_mem_ready = 1'b0;
      end
    end
    chk("reached_mem", 32'(reached), 32'd1);
    repeat (2) @(posedge i_clk);
    #3;
    chk("mem_before_reset", 32'(o_en_mem), 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk_reset("async");
    @(posedge i_clk); #2;
    chk_reset("held");
    i_run = 1'b0;
    i_mem_ready = 1'b1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    run_instr(16'h0000, 0, 16'h0000, 0, 2, 0, 16'h0001, 16'd1, 6, 1, 0, 0, 0); // restart at RESET_PC

    i_run = 1'b0;
    guard = 0;
    while (sb_q.size() > 0 && guard < 20) begin
      @(posedge i_clk);
      guard++;
    end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    repeat (3) @(posedge i_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
